// File: rtl/riscv_alu_defs.sv
// ---------------------------------------------------------------------------
// riscv_alu_defs
// Shared definitions for the RV32IM execute-stage ALU and its iterative
// multiply/divide core: aluOp codes from decode, funct3 codes for the integer,
// branch and M-extension groups, and the multiply/divide FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_alu_defs;

    // aluOp codes produced by decode
    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
    localparam logic [2:0] ALUOP_MEXT   = 3'b100;

    // funct3 codes for integer register/immediate operations
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 codes for branch compare
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // funct3 codes for the M extension
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mduState_e;

    // All M-extension divide/remainder ops have funct3[2] set
    function automatic logic isDivOp(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
// Iterative RV32M multiply/divide core. Operands are reduced to magnitudes on
// start, one bit is processed per cycle (shift-add multiply, restoring
// divide) for WIDTH cycles, then signs are restored in FIX where the result
// is presented combinationally until the parent acknowledges it.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_flush        synchronous abort back to idle
//   i_start        begin an operation (only honoured in idle)
//   i_op           M-extension funct3
//   i_a, i_b       operands (rs1, rs2)
//   i_ack          parent has captured o_result
//   o_idle         sequencer idle, ready for a new start
//   o_busy         calculating or fixing up
//   o_done         o_result valid this cycle
//   o_result       final result
// ---------------------------------------------------------------------------
module mdu_iter
    import riscv_alu_defs::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ack,
    output logic             o_idle,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    mduState_e        r_state;
    mduState_e        w_nextState;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opB;
    logic [SHW-1:0]   r_count;
    logic             r_aNeg;
    logic             r_bNeg;
    logic             r_bZero;

    logic             w_aSigned;
    logic             w_bSigned;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH:0]   w_divDiff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    // Which operands are treated as signed depends on the op; mulhsu only
    // sign-extends rs1. Magnitudes are what the iteration works on.
    assign w_aSigned = (i_op == M_MULH) || (i_op == M_MULHSU) ||
                       (i_op == M_DIV)  || (i_op == M_REM);
    assign w_bSigned = (i_op == M_MULH) || (i_op == M_DIV) || (i_op == M_REM);
    assign w_aNeg    = w_aSigned & i_a[WIDTH-1];
    assign w_bNeg    = w_bSigned & i_b[WIDTH-1];
    assign w_aMag    = w_aNeg ? (-i_a) : i_a;
    assign w_bMag    = w_bNeg ? (-i_b) : i_b;

    // One multiply step adds the multiplicand into the high half when the
    // current multiplier LSB is set, then the whole {hi,lo} pair shifts right.
    // One divide step shifts the next dividend bit into the partial
    // remainder and keeps the subtraction only if it did not go negative.
    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
    assign w_divShift = {r_hi, r_lo[WIDTH-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_opB};

    // Sign restoration. A zero divisor leaves an all-ones quotient that must
    // not be negated; the remainder is then |A| and its fixup yields A.
    // The most-negative / -1 overflow falls out naturally from the magnitudes.
    assign w_prod    = {r_hi, r_lo};
    assign w_prodFix = (r_aNeg ^ r_bNeg) ? (-w_prod) : w_prod;
    assign w_quot    = r_bZero ? '1 : ((r_aNeg ^ r_bNeg) ? (-r_lo) : r_lo);
    assign w_rem     = r_aNeg ? (-r_hi) : r_hi;

    // Result selection, presented while in FIX
    always_comb begin
        o_result = '0;
        case (r_op)
            M_MUL:                     o_result = w_prodFix[WIDTH-1:0];
            M_MULH, M_MULHSU, M_MULHU: o_result = w_prodFix[2*WIDTH-1:WIDTH];
            M_DIV, M_DIVU:             o_result = w_quot;
            default:                   o_result = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a flush always drops back to idle. FIX holds until
    // the parent can take the result so nothing is ever lost.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MDU_IDLE: if (i_start) w_nextState = MDU_CALC;
            MDU_CALC: if (r_count == LAST_ITER) w_nextState = MDU_FIX;
            MDU_FIX:  if (i_ack) w_nextState = MDU_DONE;
            default:  w_nextState = MDU_IDLE;
        endcase
        if (i_flush) begin
            w_nextState = MDU_IDLE;
        end
    end

    assign o_idle = (r_state == MDU_IDLE);
    assign o_busy = (r_state == MDU_CALC) || (r_state == MDU_FIX);
    assign o_done = (r_state == MDU_FIX);

    // Datapath: capture magnitudes on start, iterate one bit per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opB   <= '0;
            r_count <= '0;
            r_aNeg  <= 1'b0;
            r_bNeg  <= 1'b0;
            r_bZero <= 1'b0;
        end else if (r_state == MDU_IDLE && i_start && !i_flush) begin
            r_op    <= i_op;
            r_hi    <= '0;
            r_lo    <= w_aMag;
            r_opB   <= w_bMag;
            r_count <= '0;
            r_aNeg  <= w_aNeg;
            r_bNeg  <= w_bNeg;
            r_bZero <= (i_b == '0);
        end else if (r_state == MDU_CALC) begin
            r_count <= r_count + 1'b1;
            if (isDivOp(r_op)) begin
                if (!w_divDiff[WIDTH]) begin
                    r_hi <= w_divDiff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_divShift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_mulSum[WIDTH:1];
                r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// alu_mdu_seq
// RV32IM execute-stage ALU. Single-cycle integer ops and branch compare are
// computed combinationally and captured in the output register; M-extension
// ops are handed to mdu_iter. The output register decouples writeback
// stalls from issue via valid/ready on both sides.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous pipeline kill
//   inValid/inReady issue handshake
//   dataA, dataB    operands
//   func            {funct7[5], funct3}
//   aluOp           operation group
//   outValid/outReady writeback handshake
//   aluResult       registered result
//   branchFromAlu   registered branch-taken flag
//   busy            multiply/divide in progress
// ---------------------------------------------------------------------------
module alu_mdu_seq
    import riscv_alu_defs::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [3:0]       func,
    input  logic [2:0]       aluOp,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] aluResult,
    output logic             branchFromAlu,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    logic             r_outValid;
    logic [WIDTH-1:0] r_aluResult;
    logic             r_branch;

    logic             w_outFree;
    logic             w_accept;
    logic             w_singleLoad;
    logic             w_mduStart;
    logic             w_mduAck;
    logic             w_mduIdle;
    logic             w_mduBusy;
    logic             w_mduDone;
    logic [WIDTH-1:0] w_mduResult;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic             w_ltu;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_branch;

    // Handshake: accept only when the sequencer is idle and the output
    // register is empty or being drained; flush blocks acceptance outright.
    assign w_outFree    = !r_outValid || outReady;
    assign inReady      = w_mduIdle && w_outFree && !flush;
    assign w_accept     = inValid && inReady;
    assign w_mduStart   = w_accept && (aluOp == ALUOP_MEXT);
    assign w_singleLoad = w_accept && (aluOp != ALUOP_MEXT);
    assign w_mduAck     = w_mduDone && w_outFree && !flush;

    assign w_shamt = dataB[SHW-1:0];
    assign w_sum   = dataA + dataB;
    assign w_diff  = dataA - dataB;
    assign w_lt    = $signed(dataA) < $signed(dataB);
    assign w_ltu   = dataA < dataB;

    // Single-cycle datapath and branch compare. Anything undecoded yields a
    // zero result and no branch so it still completes in one cycle.
    // funct7[5] selects sub only for register adds; immediates use it only
    // to pick arithmetic right shift.
    always_comb begin
        w_aluResult = '0;
        w_branch    = 1'b0;
        case (aluOp)
            ALUOP_ADD: w_aluResult = w_sum;
            ALUOP_BRANCH: begin
                w_aluResult = w_diff;
                case (func[2:0])
                    BR_EQ:   w_branch = (dataA == dataB);
                    BR_NE:   w_branch = (dataA != dataB);
                    BR_LT:   w_branch = w_lt;
                    BR_GE:   w_branch = !w_lt;
                    BR_LTU:  w_branch = w_ltu;
                    BR_GEU:  w_branch = !w_ltu;
                    default: w_branch = 1'b0;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (func[2:0])
                    F3_ADD:  w_aluResult = (aluOp == ALUOP_RTYPE && func[3]) ? w_diff : w_sum;
                    F3_SLL:  w_aluResult = dataA << w_shamt;
                    F3_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, w_lt};
                    F3_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, w_ltu};
                    F3_XOR:  w_aluResult = dataA ^ dataB;
                    F3_SR:   w_aluResult = func[3] ? WIDTH'($signed(dataA) >>> w_shamt)
                                                   : (dataA >> w_shamt);
                    F3_OR:   w_aluResult = dataA | dataB;
                    default: w_aluResult = dataA & dataB;
                endcase
            end
            default: begin
                w_aluResult = '0;
                w_branch    = 1'b0;
            end
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mduIter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (flush),
        .i_start  (w_mduStart),
        .i_op     (func[2:0]),
        .i_a      (dataA),
        .i_b      (dataB),
        .i_ack    (w_mduAck),
        .o_idle   (w_mduIdle),
        .o_busy   (w_mduBusy),
        .o_done   (w_mduDone),
        .o_result (w_mduResult)
    );

    // Output register: holds until consumed; flush wins over everything.
    // A single-cycle load and a multiply/divide completion can never
    // coincide because accept requires the sequencer to be idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_aluResult <= '0;
            r_branch    <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_singleLoad) begin
            r_outValid  <= 1'b1;
            r_aluResult <= w_aluResult;
            r_branch    <= w_branch;
        end else if (w_mduAck) begin
            r_outValid  <= 1'b1;
            r_aluResult <= w_mduResult;
            r_branch    <= 1'b0;
        end else if (r_outValid && outReady) begin
            r_outValid <= 1'b0;
        end
    end

    assign outValid      = r_outValid;
    assign aluResult     = r_aluResult;
    assign branchFromAlu = r_branch;
    assign busy          = w_mduBusy;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_seq
// Directed-vector bench for alu_mdu_seq with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [3:0]  func;
    logic [2:0]  aluOp;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic        branchFromAlu;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    alu_mdu_seq #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .inValid       (inValid),
        .inReady       (inReady),
        .dataA         (dataA),
        .dataB         (dataB),
        .func          (func),
        .aluOp         (aluOp),
        .outValid      (outValid),
        .outReady      (outReady),
        .aluResult     (aluResult),
        .branchFromAlu (branchFromAlu),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one op with outReady high, wait (bounded) for its result and
    // report the cycle distance from the accept cycle (-1 on timeout)
    task automatic runOp(input logic [2:0] op, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic br, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!inReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        inValid = 1'b1;
        aluOp   = op;
        func    = fn;
        dataA   = a;
        dataB   = b;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = aluResult;
        br  = branchFromAlu;
        if (!outValid) lat = -1;
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic expBr, input int expLat);
        logic [31:0] res;
        logic        br;
        int          lat;
        runOp(op, fn, a, b, res, br, lat);
        checkOutput({tag, ".result"}, res, expRes);
        checkOutput({tag, ".branch"}, {31'd0, br}, {31'd0, expBr});
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    endtask

    initial begin
        int seen;
        rst_n    = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        dataA    = '0;
        dataB    = '0;
        func     = '0;
        aluOp    = '0;

        #12;
        checkOutput("reset.outValid", {31'd0, outValid}, 32'd0);
        checkOutput("reset.aluResult", aluResult, 32'd0);
        checkOutput("reset.branch", {31'd0, branchFromAlu}, 32'd0);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.inReady", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle integer ops
        applyStimulus("add",    3'b000, 4'b0000, 32'h10, 32'h20, 32'h30, 1'b0, 1);
        applyStimulus("sub",    3'b010, 4'b1000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
        applyStimulus("sra",    3'b010, 4'b1101, 32'h80000000, 32'd36, 32'hF8000000, 1'b0, 1);
        applyStimulus("sltu",   3'b010, 4'b0011, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1);
        applyStimulus("slt",    3'b010, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
        applyStimulus("sll",    3'b010, 4'b0001, 32'd1, 32'd33, 32'd2, 1'b0, 1);
        applyStimulus("xor",    3'b010, 4'b0100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1);
        applyStimulus("addiF7", 3'b011, 4'b1000, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        applyStimulus("srai",   3'b011, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
        applyStimulus("srli",   3'b011, 4'b0101, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1);
        applyStimulus("unused", 3'b111, 4'b0000, 32'd5, 32'd7, 32'd0, 1'b0, 1);

        // Branch compare
        applyStimulus("blt",    3'b001, 4'b0100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1, 1);
        applyStimulus("bltu",   3'b001, 4'b0110, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0, 1);
        applyStimulus("beq",    3'b001, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b1, 1);
        applyStimulus("brRsvd", 3'b001, 4'b0010, 32'd5, 32'd5, 32'd0, 1'b0, 1);

        // Multiply
        applyStimulus("mulh",   3'b100, 4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
        applyStimulus("mulhu",  3'b100, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
        applyStimulus("mul",    3'b100, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 34);
        applyStimulus("mul6x7", 3'b100, 4'b0000, 32'd6, 32'd7, 32'd42, 1'b0, 34);
        applyStimulus("mulhsu", 3'b100, 4'b0010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 34);

        // Divide, including zero divisor and overflow
        applyStimulus("div",    3'b100, 4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34);
        applyStimulus("rem",    3'b100, 4'b0110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
        applyStimulus("divu",   3'b100, 4'b0101, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        applyStimulus("remu",   3'b100, 4'b0111, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        applyStimulus("div0",   3'b100, 4'b0100, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 34);
        applyStimulus("divNeg0",3'b100, 4'b0100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b0, 34);
        applyStimulus("remu0",  3'b100, 4'b0111, 32'd9, 32'd0, 32'd9, 1'b0, 34);
        applyStimulus("remNeg0",3'b100, 4'b0110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0, 34);
        applyStimulus("divOvf", 3'b100, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);
        applyStimulus("remOvf", 3'b100, 4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 34);

        // Reset in the middle of a divide
        @(negedge clk);
        inValid = 1'b1; aluOp = 3'b100; func = 4'b0101; dataA = 32'd100; dataB = 32'd7;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midDiv.busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstDiv.outValid", {31'd0, outValid}, 32'd0);
        checkOutput("rstDiv.busy", {31'd0, busy}, 32'd0);
        checkOutput("rstDiv.inReady", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("divuAfterRst", 3'b100, 4'b0101, 32'd100, 32'd7, 32'd14, 1'b0, 34);

        // Backpressure: result and inReady stable while outReady is low
        @(negedge clk);
        outReady = 1'b0;
        inValid = 1'b1; aluOp = 3'b000; func = 4'b0000; dataA = 32'd1; dataB = 32'd2;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        dataA   = 32'd99;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp.outValid", {31'd0, outValid}, 32'd1);
            checkOutput("bp.aluResult", aluResult, 32'd3);
            checkOutput("bp.inReady", {31'd0, inReady}, 32'd0);
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("bpDrain.outValid", {31'd0, outValid}, 32'd0);
        checkOutput("bpDrain.inReady", {31'd0, inReady}, 32'd1);

        // Flush during CALC aborts the multiply with no result
        inValid = 1'b1; aluOp = 3'b100; func = 4'b0000; dataA = 32'd6; dataB = 32'd7;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("preFlush.busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush.inReady", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("postFlush.busy", {31'd0, busy}, 32'd0);
        checkOutput("postFlush.inReady", {31'd0, inReady}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        checkOutput("flush.noOutValid", 32'(seen), 32'd0);

        applyStimulus("addAfterFlush", 3'b000, 4'b0000, 32'd40, 32'd2, 32'd42, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
